// File: rtl/program_sequencer_pkg.sv
// Purpose : shared types and helpers for the program sequencer.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package program_sequencer_pkg;

    // One operation is selected per cycle by the priority decoder.
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_RET    = 3'd1,
        PC_CALL   = 3'd2,
        PC_LOAD   = 3'd3,
        PC_OFFSET = 3'd4,
        PC_INC    = 3'd5
    } pc_op_e;

    // Sign-extends the low offset_width bits of offset to 64 bits. The caller
    // truncates the result to its counter width, which gives a modulo add.
    function automatic logic [63:0] sign_extend_offset(input logic [63:0] offset,
                                                       input int unsigned offset_width);
        logic signed [63:0] shifted;
        shifted = $signed(offset << (64 - offset_width));
        return $unsigned(shifted >>> (64 - offset_width));
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Purpose : control and status bundle between decode/branch unit and sequencer.
// Latency : n/a (wires only).
// Backpr. : none; the decode side holds the sequencer with Stall.
// Ports   : master = decode/branch side (drives controls, reads PC/stack status);
//           slave  = program_sequencer.
interface program_sequencer_if #(
    parameter int PC_WIDTH     = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int STACK_DEPTH  = 4
);
    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                    Stall;
    logic                    ReturnEnable;
    logic                    CallEnable;
    logic                    LoadEnable;
    logic [PC_WIDTH-1:0]     LoadValue;
    logic                    OffsetEnable;
    logic [OFFSET_WIDTH-1:0] Offset;
    logic [PC_WIDTH-1:0]     CounterValue;
    logic [DEPTH_WIDTH-1:0]  StackDepth;
    logic                    StackOverflow;
    logic                    StackUnderflow;

    modport master (
        output Stall, ReturnEnable, CallEnable, LoadEnable, LoadValue,
               OffsetEnable, Offset,
        input  CounterValue, StackDepth, StackOverflow, StackUnderflow
    );

    modport slave (
        input  Stall, ReturnEnable, CallEnable, LoadEnable, LoadValue,
               OffsetEnable, Offset,
        output CounterValue, StackDepth, StackOverflow, StackUnderflow
    );

endinterface

// File: rtl/program_sequencer_return_stack.sv
// Purpose : LIFO of return addresses held in a register array.
// Latency : push/pop take effect at the clock edge; top is combinational.
// Backpr. : push ignored when full, pop ignored when empty (caller flags it).
// Ports   : Clock, Reset (sync, active-high), push/push_data, pop,
//           top (current top entry), depth, full, empty.
module return_stack #(
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   push,
    input  logic [PC_WIDTH-1:0]    push_data,
    input  logic                   pop,
    output logic [PC_WIDTH-1:0]    top,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   full,
    output logic                   empty
);

    logic [PC_WIDTH-1:0]    entries [STACK_DEPTH];
    logic [DEPTH_WIDTH-1:0] depth_q;

    assign full  = (depth_q == DEPTH_WIDTH'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + DEPTH_WIDTH'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DEPTH_WIDTH'(1);
        end
    end

    // Contents are not reset: only entries below depth are ever read.
    // Index by comparison so the depth counter (one bit wider than an
    // entry index) never addresses past the array.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && !full && (depth_q == DEPTH_WIDTH'(i))) begin
                entries[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_WIDTH'(i + 1)) begin
                top = entries[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Purpose : program counter with return-address stack for the fetch path.
// Latency : operation sampled on edge N visible on outputs right after edge N.
// Backpr. : Stall freezes PC, stack, depth and flags; other enables ignored.
// Ports   : Clock, Reset (sync, active-high), bus (program_sequencer_if.slave):
//           Stall/ReturnEnable/CallEnable/LoadEnable/LoadValue/OffsetEnable/
//           Offset in; CounterValue/StackDepth/StackOverflow/StackUnderflow out.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH     = 16,
    parameter int                  OFFSET_WIDTH = 9,
    parameter int                  STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    program_sequencer_if.slave   bus
);

    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

    pc_op_e                 op;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    pc_plus_one;
    logic [PC_WIDTH-1:0]    offset_ext;
    logic                   overflow_q;
    logic                   underflow_q;

    logic                   stack_push;
    logic                   stack_pop;
    logic [PC_WIDTH-1:0]    stack_top;
    logic [DEPTH_WIDTH-1:0] stack_depth;
    logic                   stack_full;
    logic                   stack_empty;

    // Priority decoder: exactly one operation per cycle, so masked enables
    // cannot leak side effects (e.g. a Call under a Return neither pushes
    // nor flags).
    always_comb begin
        op = PC_INC;
        if (bus.Stall) begin
            op = PC_HOLD;
        end else if (bus.ReturnEnable) begin
            op = PC_RET;
        end else if (bus.CallEnable) begin
            op = PC_CALL;
        end else if (bus.LoadEnable) begin
            op = PC_LOAD;
        end else if (bus.OffsetEnable) begin
            op = PC_OFFSET;
        end
    end

    assign pc_plus_one = pc_q + PC_WIDTH'(1);
    assign offset_ext  = PC_WIDTH'(sign_extend_offset(64'(bus.Offset), OFFSET_WIDTH));

    // A blocked push (full) or pop (empty) leaves the stack untouched;
    // the error flags below record it instead.
    assign stack_push = (op == PC_CALL) && !stack_full;
    assign stack_pop  = (op == PC_RET)  && !stack_empty;

    return_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (stack_push),
        .push_data (pc_plus_one),
        .pop       (stack_pop),
        .top       (stack_top),
        .depth     (stack_depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc_next = pc_plus_one;
        unique case (op)
            PC_HOLD:   pc_next = pc_q;
            // Underflowing return falls through to the next instruction.
            PC_RET:    pc_next = stack_empty ? pc_plus_one : stack_top;
            // Overflowing call still jumps; only the push is lost.
            PC_CALL:   pc_next = bus.LoadValue;
            PC_LOAD:   pc_next = bus.LoadValue;
            PC_OFFSET: pc_next = pc_q + offset_ext;
            PC_INC:    pc_next = pc_plus_one;
            default:   pc_next = pc_plus_one;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q        <= RESET_VECTOR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if ((op == PC_CALL) && stack_full) begin
                overflow_q <= 1'b1;
            end
            if ((op == PC_RET) && stack_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.CounterValue   = pc_q;
    assign bus.StackDepth     = stack_depth;
    assign bus.StackOverflow  = overflow_q;
    assign bus.StackUnderflow = underflow_q;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program counter with a built-in return-address stack. It supports absolute loads, signed relative branches, subroutine call/return, pipeline stall and a configurable reset vector. It sits at the front of the CPU fetch path, driving the instruction-memory address, and takes its control from the decode/branch unit.

## Interface

Parameters:
- `PC_WIDTH`, 16: width of the counter and the load value.
- `OFFSET_WIDTH`, 9: width of the signed branch offset.
- `STACK_DEPTH`, 4: number of return-address entries; must be at least 1.
- `RESET_VECTOR`, 0: value `CounterValue` takes on reset.

Ports:
- `Clock`  in  1  clock. Every state change happens on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Stall`  in  1  hold all state. Overrides every operation below.
- `ReturnEnable`  in  1  pop the top of the stack into the PC.
- `CallEnable`  in  1  push PC+1, then load `LoadValue`.
- `LoadEnable`  in  1  absolute jump to `LoadValue`.
- `LoadValue`  in  `PC_WIDTH`  jump or call target.
- `OffsetEnable`  in  1  relative branch.
- `Offset`  in  `OFFSET_WIDTH`  signed two's-complement offset.
- `CounterValue`  out  `PC_WIDTH`  current PC, registered.
- `StackDepth`  out  `$clog2(STACK_DEPTH+1)`  number of valid stack entries.
- `StackOverflow`  out  1  sticky; set by a call when the stack is full.
- `StackUnderflow`  out  1  sticky; set by a return when the stack is empty.

## Operation

- Priority, highest first: Reset, Stall, Return, Call, Load, Offset, increment.
- Reset:
  - `CounterValue` = `RESET_VECTOR`.
  - `StackDepth` = 0.
  - Both error flags = 0.
  - Stack contents are don't-care.
- Stall: PC, stack, depth and flags all hold. Every other enable is ignored, and no flag is set during a stall.
- Return with depth > 0: PC = top entry and depth decrements.
- Return with depth = 0: PC = PC+1 and `StackUnderflow` is set.
- Call with depth < `STACK_DEPTH`: push PC+1, depth increments, PC = `LoadValue`.
- Call with depth = `STACK_DEPTH`: no push and depth unchanged. `StackOverflow` is set, but the jump to `LoadValue` is still taken.
- Load: PC = `LoadValue`.
- Offset: PC = PC + sign-extended `Offset`.
- Otherwise: PC = PC+1.
- Arithmetic is modulo 2^`PC_WIDTH`; no saturation.
  - Example: 16'hFFFF + 1 = 0.
  - Example: 0 + (−1) = 16'hFFFF.
- The pushed return address also wraps, so a call at 16'hFFFF pushes 0.
- Simultaneous enables resolve by priority only. A lower-priority enable has no side effect: a Call masked by a Return neither pushes nor flags.
- Flags are sticky; only Reset clears them.

## Timing

- All outputs are registered. An operation sampled on edge N is visible on `CounterValue` and `StackDepth` immediately after edge N.
- The top-of-stack entry is read combinationally inside the block, so a return has 1-cycle latency with no bubble.
- Back-to-back operations are legal:
  - call, call, return, return on consecutive cycles.
  - A return on the cycle after a call pops the address just pushed.
- Reset asserted mid-sequence, including during a stall or a call, wins at that edge. There is no first-cycle special case; behaviour after reset is purely the reset value.
- No combinational path from any input to any output.

## Structure

- Package `program_sequencer_pkg` holds:
  - Enum `pc_op_e`: `PC_HOLD`, `PC_RET`, `PC_CALL`, `PC_LOAD`, `PC_OFFSET`, `PC_INC`.
  - A function that sign-extends the offset to `PC_WIDTH`.
- The priority decoder produces one `pc_op_e` per cycle. PC and stack updates case on that value.
- Sub-module `return_stack` is a LIFO register array. It has push, pop, top, depth, full and empty, and is parametrised by `PC_WIDTH` and `STACK_DEPTH`.

## Test plan

All scenarios use `PC_WIDTH`=16, `OFFSET_WIDTH`=9, `STACK_DEPTH`=4, `RESET_VECTOR`=16'h0100.

- Reset, then 3 idle cycles: PC = 0100, 0101, 0102, 0103; depth = 0; both flags = 0.
- PC=0200:
  - Offset = −256 gives PC = 0100.
  - Offset = +255 gives PC = 01FF.
  - At PC=FFFF, an idle cycle gives PC = 0000.
- Nested calls:
  - From PC=0010, Call to 0400 pushes 0011 and gives depth 1.
  - Call to 0500 pushes 0401 and gives depth 2.
  - Return gives PC = 0401; a second return gives PC = 0011; depth = 0.
- Stack limits:
  - Five calls from depth 0: the fifth call jumps, but depth stays 4 and `StackOverflow` = 1.
  - Four returns then give the pushed addresses in reverse order.
  - A fifth return gives PC+1 and `StackUnderflow` = 1.
- Stall and priority:
  - `Stall` with Call, Load and Offset all high: nothing changes for 3 cycles.
  - Releasing the stall with Return and Call both high pops only; no push.
- Reset asserted on the same edge as a Call at depth 3: PC = 0100, depth = 0, both flags = 0.
